// File: rtl/ghr_update_queue_if.sv
// Fetch/execute/predictor-facing bundle of the gshare update queue.
// The master side is the pipeline; the slave side is the queue.
interface ghr_update_queue_if #(
  parameter int DEPTH = 8,
  parameter int GHR_W = 6,
  parameter int PC_W  = 32
);
  localparam int TAG_W = $clog2(DEPTH);

  logic             alloc_valid;
  logic [PC_W-1:0]  alloc_pc;
  logic [GHR_W-1:0] alloc_ghr;
  logic [1:0]       alloc_counter;
  logic             alloc_ready;
  logic [TAG_W-1:0] alloc_tag;

  logic             resolve_valid;
  logic [TAG_W-1:0] resolve_tag;
  logic             resolve_taken;
  logic             resolve_mispredict;

  logic             flush;

  logic             upd_pc_valid;
  logic [PC_W-1:0]  upd_pc;
  logic             upd_pc_taken;
  logic             upd_mispredict;
  logic [GHR_W-1:0] upd_ghr;
  logic [GHR_W-1:0] upd_recover_ghr;
  logic [1:0]       upd_counter;

  modport master (
    output alloc_valid, alloc_pc, alloc_ghr, alloc_counter,
    output resolve_valid, resolve_tag, resolve_taken, resolve_mispredict,
    output flush,
    input  alloc_ready, alloc_tag,
    input  upd_pc_valid, upd_pc, upd_pc_taken, upd_mispredict,
    input  upd_ghr, upd_recover_ghr, upd_counter
  );

  modport slave (
    input  alloc_valid, alloc_pc, alloc_ghr, alloc_counter,
    input  resolve_valid, resolve_tag, resolve_taken, resolve_mispredict,
    input  flush,
    output alloc_ready, alloc_tag,
    output upd_pc_valid, upd_pc, upd_pc_taken, upd_mispredict,
    output upd_ghr, upd_recover_ghr, upd_counter
  );
endinterface

// File: rtl/ghr_update_queue.sv
// In-order branch metadata queue: allocated at fetch, resolved out of order by tag,
// retired from the head in program order as single-cycle gshare update pulses.
module ghr_update_queue #(
  parameter int DEPTH = 8,
  parameter int GHR_W = 6,
  parameter int PC_W  = 32
) (
  input logic               clk,
  input logic               reset,
  ghr_update_queue_if.slave bus
);
  localparam int TAG_W = $clog2(DEPTH);
  typedef logic [TAG_W-1:0] tag_t;
  localparam tag_t TAG_ONE = tag_t'(1);

  // Distance of an entry from the head; a larger value means a younger branch.
  function automatic tag_t age_of(input tag_t idx, input tag_t head);
    return idx - head;
  endfunction

  function automatic logic [GHR_W-1:0] recover_ghr(input logic [GHR_W-1:0] ghr,
                                                   input logic taken);
    return {ghr[GHR_W-2:0], taken};
  endfunction

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] resolved_q, resolved_d;
  logic [DEPTH-1:0] taken_q, taken_d;
  logic [DEPTH-1:0] misp_q, misp_d;
  tag_t             head_q, head_d;
  tag_t             tail_q, tail_d;

  logic [PC_W-1:0]  pc_q  [DEPTH];
  logic [GHR_W-1:0] ghr_q [DEPTH];
  logic [1:0]       cnt_q [DEPTH];

  logic             upd_valid_q, upd_valid_d;
  logic [PC_W-1:0]  upd_pc_q, upd_pc_d;
  logic             upd_taken_q, upd_taken_d;
  logic             upd_misp_q, upd_misp_d;
  logic [GHR_W-1:0] upd_ghr_q, upd_ghr_d;
  logic [GHR_W-1:0] upd_rec_q, upd_rec_d;
  logic [1:0]       upd_cnt_q, upd_cnt_d;

  tag_t res_tag;
  logic full;
  logic res_hit;
  logic squash;
  logic alloc_fire;
  logic head_hit;
  logic retire;
  logic ret_taken;
  logic ret_misp;

  // Occupancy comes from the valid bits; head==tail is ambiguous between empty and full.
  assign res_tag    = bus.resolve_tag;
  assign full       = valid_q[tail_q];
  assign res_hit    = bus.resolve_valid & valid_q[res_tag] & ~resolved_q[res_tag];
  assign squash     = res_hit & bus.resolve_mispredict;
  assign alloc_fire = bus.alloc_valid & ~full & ~bus.flush & ~squash;
  assign head_hit   = res_hit & (res_tag == head_q);
  assign retire     = ~bus.flush & valid_q[head_q] & (resolved_q[head_q] | head_hit);
  assign ret_taken  = head_hit ? bus.resolve_taken      : taken_q[head_q];
  assign ret_misp   = head_hit ? bus.resolve_mispredict : misp_q[head_q];

  // Queue control next state: flush, then resolve, squash, alloc and retire.
  always_comb begin
    valid_d    = valid_q;
    resolved_d = resolved_q;
    taken_d    = taken_q;
    misp_d     = misp_q;
    head_d     = head_q;
    tail_d     = tail_q;
    if (bus.flush) begin
      valid_d = '0;
      head_d  = '0;
      tail_d  = '0;
    end else begin
      if (res_hit) begin
        resolved_d[res_tag] = 1'b1;
        taken_d[res_tag]    = bus.resolve_taken;
        misp_d[res_tag]     = bus.resolve_mispredict;
      end else begin
        resolved_d = resolved_q;
      end
      for (int i = 0; i < DEPTH; i++) begin
        valid_d[i] = valid_d[i] &
                     ~(squash & (age_of(tag_t'(i), head_q) > age_of(res_tag, head_q)));
      end
      if (squash) begin
        tail_d = res_tag + TAG_ONE;
      end else if (alloc_fire) begin
        valid_d[tail_q]    = 1'b1;
        resolved_d[tail_q] = 1'b0;
        tail_d             = tail_q + TAG_ONE;
      end else begin
        tail_d = tail_q;
      end
      if (retire) begin
        valid_d[head_q] = 1'b0;
        head_d          = head_q + TAG_ONE;
      end else begin
        head_d = head_q;
      end
    end
  end

  // Update-port next state: pulse on retire, otherwise hold the last retired fields.
  always_comb begin
    upd_valid_d = retire;
    upd_pc_d    = upd_pc_q;
    upd_taken_d = upd_taken_q;
    upd_misp_d  = upd_misp_q;
    upd_ghr_d   = upd_ghr_q;
    upd_rec_d   = upd_rec_q;
    upd_cnt_d   = upd_cnt_q;
    if (retire) begin
      upd_pc_d    = pc_q[head_q];
      upd_taken_d = ret_taken;
      upd_misp_d  = ret_misp;
      upd_ghr_d   = ghr_q[head_q];
      upd_rec_d   = recover_ghr(ghr_q[head_q], ret_taken);
      upd_cnt_d   = cnt_q[head_q];
    end else begin
      upd_valid_d = 1'b0;
    end
  end

  // Control and update-port registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q     <= '0;
      resolved_q  <= '0;
      taken_q     <= '0;
      misp_q      <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      upd_valid_q <= 1'b0;
      upd_pc_q    <= '0;
      upd_taken_q <= 1'b0;
      upd_misp_q  <= 1'b0;
      upd_ghr_q   <= '0;
      upd_rec_q   <= '0;
      upd_cnt_q   <= 2'b00;
    end else begin
      valid_q     <= valid_d;
      resolved_q  <= resolved_d;
      taken_q     <= taken_d;
      misp_q      <= misp_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      upd_valid_q <= upd_valid_d;
      upd_pc_q    <= upd_pc_d;
      upd_taken_q <= upd_taken_d;
      upd_misp_q  <= upd_misp_d;
      upd_ghr_q   <= upd_ghr_d;
      upd_rec_q   <= upd_rec_d;
      upd_cnt_q   <= upd_cnt_d;
    end
  end

  // Prediction-time payload; only read while the entry is valid, so it needs no reset.
  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      pc_q[tail_q]  <= bus.alloc_pc;
      ghr_q[tail_q] <= bus.alloc_ghr;
      cnt_q[tail_q] <= bus.alloc_counter;
    end
  end

  assign bus.alloc_ready     = ~full;
  assign bus.alloc_tag       = tail_q;
  assign bus.upd_pc_valid    = upd_valid_q;
  assign bus.upd_pc          = upd_pc_q;
  assign bus.upd_pc_taken    = upd_taken_q;
  assign bus.upd_mispredict  = upd_misp_q;
  assign bus.upd_ghr         = upd_ghr_q;
  assign bus.upd_recover_ghr = upd_rec_q;
  assign bus.upd_counter     = upd_cnt_q;
endmodule
